mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_pkg.sv | 13 +
 rtl/mac_feeder_fifo.sv | 41 ++++
 rtl/mac_feeder.sv | 89 ++++++++
 tb/tb_mac_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, saturation limits, FSM states and FIFO entry for mac_feeder
package mac_pkg;
    localparam int OP_W  = 14;
    localparam int ACC_W = 28;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, CAPTURE, CLEAR} state_t;
    typedef struct packed {
        logic signed [OP_W-1:0] a;
        logic signed [OP_W-1:0] b;
        logic                   last;
    } fifo_entry_t;
endpackage

// File: rtl/mac_feeder_fifo.sv
// mac_feeder_fifo: operand-pair FIFO with full/empty flags and a sticky drop indicator
module mac_feeder_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_wr, do_rd;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];
    // full is judged before any same-cycle pop, so such a write is still dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {wr_ptr, rd_ptr, count, overflow} <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(do_wr);
            rd_ptr   <= rd_ptr + AW'(do_rd);
            count    <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            overflow <= overflow | (wr_en & full);
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: streams FIFO'd operand pairs into a MAC and captures each dot product.
// Optional saturation flag: define MAC_FEEDER_SAT_FLAG_EN.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAC_LAT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic signed [OP_W-1:0]  wr_a,
    input  logic signed [OP_W-1:0]  wr_b,
    input  logic                    wr_last,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic signed [OP_W-1:0]  mac_a,
    output logic signed [OP_W-1:0]  mac_b,
    output logic                    mac_valid,
    output logic                    mac_clear,
    input  logic signed [ACC_W-1:0] mac_f,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    output logic                    sat
);
    localparam int CW = $clog2(MAC_LAT + 1);
    state_t        state, next;
    logic [CW-1:0] cnt, cnt_next;
    logic          pop;
    fifo_entry_t   wr_entry, head;
    assign wr_entry = '{a: wr_a, b: wr_b, last: wr_last};
    mac_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_entry), .rd_en(pop),
        .rd_data(head), .full(full), .empty(empty), .overflow(overflow)
    );
    always_comb begin
        next     = state;
        cnt_next = cnt;
        pop      = 1'b0;
        case (state)
            IDLE:    next = empty ? IDLE : STREAM;
            STREAM: begin
                pop = !empty;
                if (!empty && head.last) begin
                    next     = DRAIN;
                    cnt_next = CW'(MAC_LAT);
                end
            end
            DRAIN: begin
                cnt_next = cnt - CW'(1);
                next     = (cnt == CW'(1)) ? CAPTURE : DRAIN;
            end
            CAPTURE: next = CLEAR;
            CLEAR:   next = empty ? IDLE : STREAM;
            default: next = IDLE;
        endcase
    end
    // mac_clear trails CLEAR by a cycle so it lands right after the result strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mac_valid    <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_clear    <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= next;
            cnt          <= cnt_next;
            mac_valid    <= pop;
            mac_a        <= pop ? head.a : mac_a;
            mac_b        <= pop ? head.b : mac_b;
            mac_clear    <= state == CLEAR;
            result       <= (state == CAPTURE) ? mac_f : result;
            result_valid <= state == CAPTURE;
        end
    end
`ifdef MAC_FEEDER_SAT_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sat <= 1'b0;
        else if (state == CAPTURE) sat <= (mac_f == SAT_MAX) || (mac_f == SAT_MIN);
    end
`else
    assign sat = 1'b0;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: randomized and directed checks of mac_feeder against a saturating dot-product model
module tb_mac_feeder;
    localparam int DEPTH = 16;
    localparam int MAC_LAT = 3;
    localparam longint MAXV = 134217727;
    localparam longint MINV = -134217728;
`ifdef MAC_FEEDER_SAT_FLAG_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, wr_last = 1'b0;
    logic signed [13:0] wr_a = '0, wr_b = '0, mac_a, mac_b;
    logic full, empty, overflow, mac_valid, mac_clear, result_valid, sat;
    logic signed [27:0] mac_f, result;
    int checks = 0, failures = 0;
    longint acc = 0, p1 = 0, p2 = 0;

    always #5 clk = ~clk;

    mac_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .wr_last(wr_last),
        .full(full), .empty(empty), .overflow(overflow), .mac_a(mac_a), .mac_b(mac_b),
        .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_f(mac_f), .result(result),
        .result_valid(result_valid), .sat(sat)
    );

    function automatic longint sat_acc(longint s, longint a, longint b);
        longint t = s + a * b;
        return (t > MAXV) ? MAXV : (t < MINV) ? MINV : t;
    endfunction

    function automatic logic exp_sat(longint e);
        return SAT_EN && (e == MAXV || e == MINV);
    endfunction

    function automatic int rnd_op();
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 1) ? 8191 : -8192;
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // MAC environment: saturating accumulate, product visible on f MAC_LAT cycles after valid
    always @(posedge clk) begin
        if (mac_clear) begin
            acc <= 0; p1 <= 0; p2 <= 0;
        end else begin
            if (mac_valid) acc <= sat_acc(acc, longint'(mac_a), longint'(mac_b));
            p1 <= acc;
            p2 <= p1;
        end
    end
    assign mac_f = 28'(p2);

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int a, input int b, input bit last);
        wr_a = 14'(a); wr_b = 14'(b); wr_last = last; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic get_result(input int budget, output logic signed [27:0] r, output logic s,
                              output logic clr, output logic rv, output bit got);
        got = 0; r = '0; s = 0; clr = 0; rv = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                got = 1; r = result; s = sat;
                @(posedge clk); #1;
                clr = mac_clear; rv = result_valid;
            end
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b want=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b want=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        checks++; if (mac_a !== 14'sd0 || mac_b !== 14'sd0) begin failures++; $display("FAIL reset_operands got=%0d,%0d want=0,0", mac_a, mac_b); end
        checks++; if (mac_valid !== 1'b0) begin failures++; $display("FAIL reset_mac_valid got=%0b want=0", mac_valid); end
        checks++; if (mac_clear !== 1'b1) begin failures++; $display("FAIL reset_mac_clear got=%0b want=1", mac_clear); end
        checks++; if (result !== 28'sd0 || result_valid !== 1'b0) begin failures++; $display("FAIL reset_result got=%0d/%0b want=0/0", result, result_valid); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b want=0", sat); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (mac_clear !== 1'b0) begin failures++; $display("FAIL reset_release_clear got=%0b want=0", mac_clear); end
        tick(3);
    endtask

    task automatic test_vector(input string name, input int a[$], input int b[$], input longint want);
        logic signed [27:0] r; logic s, clr, rv; bit got;
        fork
            foreach (a[i]) send(a[i], b[i], i == a.size() - 1);
            get_result(100, r, s, clr, rv, got);
        join
        tick(3);
        checks++; if (!got) begin failures++; $display("FAIL %s_timeout got=none want=result_valid", name); end
        checks++; if (r !== 28'(want)) begin failures++; $display("FAIL %s_result got=%0d want=%0d", name, r, want); end
        checks++; if (s !== exp_sat(want)) begin failures++; $display("FAIL %s_sat got=%0b want=%0b", name, s, exp_sat(want)); end
        checks++; if (clr !== 1'b1 || rv !== 1'b0) begin failures++; $display("FAIL %s_next_cycle got clear=%0b rv=%0b want clear=1 rv=0", name, clr, rv); end
    endtask

    task automatic test_directed;
        int qa[$], qb[$];
        qa = {1000, -1000, 1300}; qb = {1000, 1260, 1780};
        test_vector("dot3", qa, qb, 2054000);
        qa = {8191, 8191, 8191}; qb = {8191, 8191, 8191};
        test_vector("sat_max", qa, qb, MAXV);
        qa = {-8192, -8192, -8192}; qb = {8191, 8191, 8191};
        test_vector("sat_min", qa, qb, MINV);
        qa = {-5}; qb = {7};
        test_vector("one_element", qa, qb, -35);
    endtask

    task automatic test_bubbles;
        int nv = 0, bub = 0, clr_seen = 0;
        bit got = 0;
        longint e = 0;
        logic signed [27:0] r = '0;
        for (int i = 0; i < 40; i++) begin
            wr_en = (i == 0 || i == 1 || i == 7); wr_last = (i == 7);
            wr_a = 14'(100 + i); wr_b = 14'(i - 20);
            if (wr_en) e = sat_acc(e, 100 + i, i - 20);
            @(posedge clk); #1;
            wr_en = 1'b0; wr_last = 1'b0;
            // the FSM enters STREAM one cycle after the first write
            if (i >= 1 && nv < 3) begin if (mac_valid) nv++; else bub++; end
            if (mac_clear && !got) clr_seen++;
            if (result_valid && !got) begin got = 1; r = result; end
        end
        checks++; if (nv !== 3) begin failures++; $display("FAIL bubble_valids got=%0d want=3", nv); end
        checks++; if (bub !== 5) begin failures++; $display("FAIL bubble_count got=%0d want=5", bub); end
        checks++; if (clr_seen !== 0) begin failures++; $display("FAIL bubble_clear got=%0d want=0", clr_seen); end
        checks++; if (!got || r !== 28'(e)) begin failures++; $display("FAIL bubble_result got=%0d want=%0d", r, e); end
    endtask

    task automatic test_back_to_back;
        int va[4] = '{300, -450, 1234, 77};
        int vb[4] = '{-21, 600, 5, -8000};
        int vidx[$];
        longint e1, e2;
        logic signed [27:0] res[$];
        e1 = sat_acc(sat_acc(0, va[0], vb[0]), va[1], vb[1]);
        e2 = sat_acc(sat_acc(0, va[2], vb[2]), va[3], vb[3]);
        for (int i = 0; i < 40; i++) begin
            wr_en = (i < 4); wr_last = (i == 1 || i == 3);
            wr_a = 14'(va[i % 4]); wr_b = 14'(vb[i % 4]);
            @(posedge clk); #1;
            wr_en = 1'b0; wr_last = 1'b0;
            if (mac_valid) vidx.push_back(i);
            if (result_valid) res.push_back(result);
        end
        checks++; if (vidx.size() !== 4) begin failures++; $display("FAIL b2b_valids got=%0d want=4", vidx.size()); end
        checks++; if (vidx.size() < 3 || vidx[2] - vidx[1] - 1 !== MAC_LAT + 2) begin failures++; $display("FAIL b2b_gap got=%0d want=%0d", (vidx.size() < 3) ? -1 : vidx[2] - vidx[1] - 1, MAC_LAT + 2); end
        checks++; if (res.size() !== 2 || res[0] !== 28'(e1) || res[1] !== 28'(e2)) begin failures++; $display("FAIL b2b_results got=%0d items want=%0d,%0d", res.size(), e1, e2); end
    endtask

    task automatic test_random;
        int lens[$], as[$], bs[$];
        longint exp_q[$];
        int nvec = 25;
        for (int v = 0; v < nvec; v++) begin
            int len = $urandom_range(1, 6);
            longint e = 0;
            for (int k = 0; k < len; k++) begin
                int a = rnd_op(), b = rnd_op();
                as.push_back(a); bs.push_back(b);
                e = sat_acc(e, a, b);
            end
            lens.push_back(len); exp_q.push_back(e);
        end
        fork
            begin
                int idx = 0;
                foreach (lens[v]) begin
                    for (int k = 0; k < lens[v]; k++) begin
                        send(as[idx], bs[idx], k == lens[v] - 1);
                        idx++;
                        tick($urandom_range(0, 2));
                    end
                    tick(8);
                end
            end
            begin
                for (int v = 0; v < nvec; v++) begin
                    logic signed [27:0] r; logic s, clr, rv; bit got;
                    get_result(400, r, s, clr, rv, got);
                    checks++; if (!got || r !== 28'(exp_q[v])) begin failures++; $display("FAIL random_result[%0d] got=%0d want=%0d", v, r, exp_q[v]); end
                    checks++; if (s !== exp_sat(exp_q[v])) begin failures++; $display("FAIL random_sat[%0d] got=%0b want=%0b", v, s, exp_sat(exp_q[v])); end
                    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL random_clear[%0d] got=%0b want=1", v, clr); end
                end
            end
        join
        tick(5);
        checks++; if (overflow !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL random_end got ovf=%0b empty=%0b want 0/1", overflow, empty); end
    endtask

    task automatic test_overflow;
        bit full_seen = 0;
        logic signed [27:0] res[$];
        fork
            for (int k = 0; k < 30; k++) begin
                send(k + 100, -3, 1'b1);
                full_seen |= full;
            end
            begin
                bit more = 1;
                while (more && res.size() < 40) begin
                    logic signed [27:0] r; logic s, clr, rv;
                    get_result(60, r, s, clr, rv, more);
                    if (more) res.push_back(r);
                end
            end
        join
        checks++; if (!full_seen) begin failures++; $display("FAIL ovf_full got=0 want=1"); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
        checks++; if (res.size() < 16 || res.size() > 29) begin failures++; $display("FAIL ovf_count got=%0d want=16..29", res.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (res.size() <= i || res[i] !== 28'((i + 100) * -3)) begin failures++; $display("FAIL ovf_result[%0d] got=%0d want=%0d", i, (res.size() > i) ? res[i] : 28'sd0, (i + 100) * -3); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%0b want=1", empty); end
    endtask

    task automatic test_reset_drain;
        int nv = 0, rv_seen = 0, mv_seen = 0;
        for (int i = 0; i < 20 && nv < 2; i++) begin
            wr_en = (i < 4); wr_last = (i == 1);
            wr_a = 14'(50 + i); wr_b = 14'(60 - i);
            @(posedge clk); #1;
            wr_en = 1'b0; wr_last = 1'b0;
            if (mac_valid) nv++;
        end
        checks++; if (nv !== 2) begin failures++; $display("FAIL rst_drain_reach got=%0d want=2", nv); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mac_clear !== 1'b1 || mac_valid !== 1'b0) begin failures++; $display("FAIL rst_drain_mac got clear=%0b valid=%0b want 1/0", mac_clear, mac_valid); end
        checks++; if (result_valid !== 1'b0 || result !== 28'sd0 || sat !== 1'b0) begin failures++; $display("FAIL rst_drain_result got=%0d/%0b/%0b want=0/0/0", result, result_valid, sat); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_drain_fifo got e=%0b f=%0b o=%0b want 1/0/0", empty, full, overflow); end
        checks++; if (mac_a !== 14'sd0 || mac_b !== 14'sd0) begin failures++; $display("FAIL rst_drain_operands got=%0d,%0d want=0,0", mac_a, mac_b); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (result_valid) rv_seen++;
            if (mac_valid) mv_seen++;
        end
        checks++; if (rv_seen !== 0 || mv_seen !== 0) begin failures++; $display("FAIL rst_drain_after got rv=%0d mv=%0d want 0/0", rv_seen, mv_seen); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        tick(5);
        test_bubbles();
        tick(5);
        test_back_to_back();
        tick(5);
        test_random();
        tick(5);
        test_overflow();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
